instruction_loader: RTL and testbench



---
 rtl/instruction_loader_pkg.sv | 26 ++
 rtl/instruction_loader.sv | 123 ++++++++++++
 tb/tb_instruction_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and fetch: widths, FSM encoding,
// and the byte order of a 16-bit instruction in the byte-wide instruction memory.
package instruction_loader_pkg;

  localparam int ADDR_W  = 8;
  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;

  // Byte offset of each half of an instruction relative to its base address.
  localparam logic LO_BYTE = 1'b0;
  localparam logic HI_BYTE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } loader_state_e;

  function automatic logic [BYTE_W-1:0] instrByte(input logic [INSTR_W-1:0] word,
                                                  input logic sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/instruction_loader.sv
// Streams 16-bit instructions into the byte-wide instruction memory as two byte
// writes (low byte at ptr, high byte at ptr+1). Optional LOADER_CHECKSUM_EN adds a byte checksum.
module instruction_loader
  import instruction_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    baseAddress,
  input  logic [7:0]           wordCount,
  input  logic                 inValid,
  input  logic [INSTR_W-1:0]   inWord,
  output logic                 inReady,
  output logic                 memWrite,
  output logic [ADDR_W-1:0]    memAddress,
  output logic [BYTE_W-1:0]    memData,
  output logic                 busy,
  output logic                 done,
  output logic                 cpuHold,
`ifdef LOADER_CHECKSUM_EN
  output logic [BYTE_W-1:0]    checksum,
`endif
  output loader_state_e        dbgState
);

  // Handshake: a word transfers on a rising edge where inValid && inReady are both 1;
  // inReady depends only on the registered state, never on inValid.

  loader_state_e       state, nextState;
  logic [ADDR_W-1:0]   ptr;
  logic [7:0]          remaining;
  logic [INSTR_W-1:0]  word;
  logic                startAccept;
  logic                wordAccept;

  assign startAccept = (state == IDLE) && start;
  assign wordAccept  = (state == LOAD) && inValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      word      <= '0;
    end else begin
      state <= nextState;
      if (startAccept) begin
        ptr       <= baseAddress;
        remaining <= wordCount;
      end
      if (wordAccept) begin
        word <= inWord;
      end
      // ptr wraps modulo 256, so an instruction may straddle 0xFF/0x00.
      if (state == WR_LO) begin
        ptr <= ptr + 8'd1;
      end
      if (state == WR_HI) begin
        ptr       <= ptr + 8'd1;
        remaining <= remaining - 8'd1;
      end
    end
  end

  always_comb begin
    nextState  = state;
    inReady    = 1'b0;
    memWrite   = 1'b0;
    memAddress = '0;
    memData    = '0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = (wordCount == 8'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        inReady = 1'b1;
        if (inValid) begin
          nextState = WR_LO;
        end
      end
      WR_LO: begin
        memWrite   = 1'b1;
        memAddress = ptr;
        memData    = instrByte(word, LO_BYTE);
        nextState  = WR_HI;
      end
      WR_HI: begin
        memWrite   = 1'b1;
        memAddress = ptr;
        memData    = instrByte(word, HI_BYTE);
        nextState  = (remaining == 8'd1) ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  assign busy     = (state == LOAD) || (state == WR_LO) || (state == WR_HI);
  assign cpuHold  = busy;
  assign dbgState = state;

`ifdef LOADER_CHECKSUM_EN
  // Running sum of every byte written; holds from DONE until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (startAccept) begin
      checksum <= '0;
    end else if (memWrite) begin
      checksum <= checksum + memData;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed-plus-random bench for instruction_loader: the expected byte-write stream
// is derived from base address, word index and byte offset with plain modulo arithmetic.
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    baseAddress = '0;
  logic [7:0]    wordCount = '0;
  logic          inValid = 1'b0;
  logic [15:0]   inWord = '0;
  logic          inReady;
  logic          memWrite;
  logic [7:0]    memAddress;
  logic [7:0]    memData;
  logic          busy;
  logic          done;
  logic          cpuHold;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif
  loader_state_e dbgState;

  int            testsRun = 0;
  int            failCount = 0;
  int            writeSeen = 0;
  int            doneSeen = 0;
  logic [15:0]   exp_q[$];
  logic [15:0]   words[256];

  instruction_loader dut (
    .clk(clk), .reset(reset), .start(start), .baseAddress(baseAddress),
    .wordCount(wordCount), .inValid(inValid), .inWord(inWord), .inReady(inReady),
    .memWrite(memWrite), .memAddress(memAddress), .memData(memData), .busy(busy),
    .done(done), .cpuHold(cpuHold),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbgState(dbgState)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWrite === 1'b1) writeSeen++;
    if (done === 1'b1) doneSeen++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one full load. gapMode 0 = back-to-back, 1 = random gaps, 2 = 5-cycle gaps with a stray start.
  task automatic runLoad(input logic [7:0] base, input int count, input int gapMode);
    logic [7:0]  sum;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [15:0] exp;
    int          gap;
    int          w0;
    int          d0;
    exp_q.delete();
    sum = 8'h00;
    for (int i = 0; i < count; i++) begin
      for (int b = 0; b < 2; b++) begin
        a = 8'((int'(base) + 2 * i + b) % 256);
        d = (b == 0) ? words[i][7:0] : words[i][15:8];
        exp_q.push_back({a, d});
        sum = sum + d;
      end
    end
    w0 = writeSeen;
    d0 = doneSeen;
    start = 1'b1; baseAddress = base; wordCount = 8'(count);
    @(negedge clk);
    start = 1'b0; baseAddress = 8'($urandom); wordCount = 8'($urandom);
    if (count == 0) begin
      check("zero_done", {15'd0, done}, 16'd1);
      check("zero_busy", {15'd0, busy}, 16'd0);
      check("zero_memWrite", {15'd0, memWrite}, 16'd0);
      @(negedge clk);
      check("zero_idle_done", {15'd0, done}, 16'd0);
      check("zero_writes", 16'(writeSeen - w0), 16'd0);
      check("zero_done_count", 16'(doneSeen - d0), 16'd1);
      return;
    end
    check("load_inReady", {15'd0, inReady}, 16'd1);
    check("load_busy", {15'd0, busy}, 16'd1);
    check("load_cpuHold", {15'd0, cpuHold}, 16'd1);
    for (int i = 0; i < count; i++) begin
      gap = (gapMode == 1) ? int'($urandom_range(0, 3)) : (gapMode == 2) ? 5 : 0;
      for (int g = 0; g < gap; g++) begin
        inWord = 16'($urandom);
        start = (gapMode == 2 && g == 2);
        baseAddress = 8'($urandom); wordCount = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        check("wait_inReady", {15'd0, inReady}, 16'd1);
        check("wait_memWrite", {15'd0, memWrite}, 16'd0);
      end
      inValid = 1'b1; inWord = words[i];
      @(negedge clk);
      inValid = 1'b0; inWord = 16'($urandom);
      exp = exp_q.pop_front();
      check("lo_memWrite", {15'd0, memWrite}, 16'd1);
      check("lo_addr_data", {memAddress, memData}, exp);
      check("lo_inReady", {15'd0, inReady}, 16'd0);
      @(negedge clk);
      exp = exp_q.pop_front();
      check("hi_memWrite", {15'd0, memWrite}, 16'd1);
      check("hi_addr_data", {memAddress, memData}, exp);
      check("hi_busy", {15'd0, busy}, 16'd1);
      @(negedge clk);
      if (i == count - 1) begin
        check("end_done", {15'd0, done}, 16'd1);
        check("end_busy", {15'd0, busy}, 16'd0);
        check("end_cpuHold", {15'd0, cpuHold}, 16'd0);
        check("end_memWrite", {15'd0, memWrite}, 16'd0);
`ifdef LOADER_CHECKSUM_EN
        check("end_checksum", {8'h00, checksum}, {8'h00, sum});
`endif
      end else begin
        check("next_inReady", {15'd0, inReady}, 16'd1);
      end
    end
    @(negedge clk);
    check("idle_done", {15'd0, done}, 16'd0);
    check("idle_inReady", {15'd0, inReady}, 16'd0);
    check("write_count", 16'(writeSeen - w0), 16'(2 * count));
    check("done_count", 16'(doneSeen - d0), 16'd1);
`ifdef LOADER_CHECKSUM_EN
    check("idle_checksum", {8'h00, checksum}, {8'h00, sum});
`endif
  endtask

  initial begin
    int w0;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state", 16'(dbgState), 16'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("rst_inReady", {15'd0, inReady}, 16'd0);
    check("rst_memWrite", {15'd0, memWrite}, 16'd0);
    check("rst_memAddress", {8'h00, memAddress}, 16'h0000);
    check("rst_memData", {8'h00, memData}, 16'h0000);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_cpuHold", {15'd0, cpuHold}, 16'd0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_checksum", {8'h00, checksum}, 16'h0000);
`endif
    w0 = writeSeen;
    for (int i = 0; i < 10; i++) begin
      inValid = 1'(($urandom));
      inWord = 16'($urandom);
      @(negedge clk);
    end
    inValid = 1'b0;
    check("idle_no_writes", 16'(writeSeen - w0), 16'd0);

    // Directed loads
    words[0] = 16'hA1B2; words[1] = 16'hC3D4;
    runLoad(8'h10, 2, 0);
    words[0] = 16'h1234;
    runLoad(8'hFF, 1, 0);
    runLoad(8'h00, 0, 0);
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    runLoad(8'($urandom), 3, 2);

    // Random loads, including odd and wrapping bases
    for (int t = 0; t < 8; t++) begin
      int n;
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      runLoad(8'($urandom_range(0, 255)), n, int'($urandom_range(0, 1)));
    end

    // Reset during WR_LO of the first word
    start = 1'b1; baseAddress = 8'h40; wordCount = 8'd2;
    @(negedge clk);
    start = 1'b0;
    inValid = 1'b1; inWord = 16'($urandom);
    @(negedge clk);
    inValid = 1'b0;
    check("rst_mid_lo_write", {15'd0, memWrite}, 16'd1);
    reset = 1'b1;
    @(negedge clk);
    w0 = writeSeen;
    check("rst_mid_memWrite", {15'd0, memWrite}, 16'd0);
    check("rst_mid_state", 16'(dbgState), 16'(IDLE));
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_writes", 16'(writeSeen - w0), 16'd0);
`ifdef LOADER_CHECKSUM_EN
    check("rst_mid_checksum", {8'h00, checksum}, 16'h0000);
`endif
    words[0] = 16'($urandom);
    runLoad(8'h7F, 1, 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
